// File: rtl/hazard_ctrl.sv
// Stall/bubble/flush/forwarding sequencer for the 5-stage RV32I pipeline, with data-memory wait FSM.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int RA_W   = 5,
    parameter int MEM_TO = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic [RA_W-1:0] ex_rs1,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_reg_wb,
    input  logic            ex_load,
    input  logic            ex_redirect,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            stall_pc,
    output logic            stall_ifid,
    output logic            bubble_idex,
    output logic            flush_ifid,
    output logic            freeze,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            mem_err,
    output logic [1:0]      state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall,
    output logic [15:0]     perf_flush,
    output logic [15:0]     perf_lu
`endif
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;
    localparam logic [7:0] TO_LIM  = 8'(MEM_TO);

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [7:0]      wait_cnt;
    logic [7:0]      cnt_d;
    logic            err_set;
    logic [RA_W-1:0] mem_rd;
    logic [RA_W-1:0] wb_rd;
    logic            mem_load;
    logic            bubble_idex_p1;
    logic            load_use;
    logic            redirect_act;
    logic            lu_act;

    // MEM result is preferred over WB; loads in MEM have no data yet, x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_rd != '0 && mem_rd == rs && !mem_load)
            sel = 2'b01;
        else if (wb_rd != '0 && wb_rd == rs)
            sel = 2'b10;
        return sel;
    endfunction

    // The counter value after this edge is what gets compared, so MEM_TO cycles of freeze precede ERR.
    always_comb begin
        state_d = state_q;
        cnt_d   = wait_cnt;
        err_set = 1'b0;
        freeze  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze = 1'b1;
                    cnt_d  = 8'd1;
                    if (cnt_d >= TO_LIM) begin
                        state_d = ST_ERR;
                        err_set = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                freeze = 1'b1;
                if (mem_ready) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = wait_cnt + 8'd1;
                    if (cnt_d >= TO_LIM) begin
                        state_d = ST_ERR;
                        err_set = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_RUN;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        load_use = ex_load && ex_reg_wb && (ex_rd != '0) &&
                   ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
        redirect_act = ex_redirect && !freeze;
        lu_act       = load_use && !ex_redirect && !freeze;
        flush_ifid   = redirect_act;
        bubble_idex  = redirect_act || lu_act;
        stall_pc     = lu_act;
        stall_ifid   = lu_act;
        fwd_a        = fwd_sel(ex_rs1);
        fwd_b        = fwd_sel(ex_rs2);
    end

    assign state = state_q;

    // Stage boundary: EX -> MEM -> WB destination trackers, held while frozen.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_RUN;
            wait_cnt       <= 8'd0;
            mem_err        <= 1'b0;
            mem_rd         <= '0;
            wb_rd          <= '0;
            mem_load       <= 1'b0;
            bubble_idex_p1 <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= cnt_d;
            if (err_set)
                mem_err <= 1'b1;
            if (!freeze) begin
                mem_rd         <= (ex_reg_wb && !bubble_idex_p1) ? ex_rd : '0;
                mem_load       <= ex_load;
                wb_rd          <= mem_rd;
                bubble_idex_p1 <= bubble_idex;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_lu    <= '0;
        end else begin
            if ((stall_pc || freeze) && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
            if (flush_ifid && perf_flush != '1)
                perf_flush <= perf_flush + 16'd1;
            if (lu_act && perf_lu != '1)
                perf_lu <= perf_lu + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one instance at default MEM_TO, one at MEM_TO=3 for timeout.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_use1;
        logic       id_use2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_reg_wb;
        logic       ex_load;
        logic       ex_redirect;
        logic       mem_req;
        logic       mem_ready;
    } stim_t;

    // ctl = {freeze, flush_ifid, bubble_idex, stall_ifid, stall_pc}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b00111;
    localparam logic [4:0] C_RD   = 5'b01100;
    localparam logic [4:0] C_FZ   = 5'b10000;

    logic  clk = 1'b0;
    logic  reset_n;
    stim_t s;
    int    checks = 0;
    int    errors = 0;

    logic [12:0] exp_q[$];

    logic       m_stall_pc, m_stall_ifid, m_bubble, m_flush, m_freeze, m_err;
    logic [1:0] m_fwd_a, m_fwd_b, m_state;
    logic       t_stall_pc, t_stall_ifid, t_bubble, t_flush, t_freeze, t_err;
    logic [1:0] t_fwd_a, t_fwd_b, t_state;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] m_perf_stall, t_perf_stall;
    logic [15:0] m_perf_flush, t_perf_flush, m_perf_lu, t_perf_lu;
`endif

    logic [11:0] obs_m, obs_t;
    assign obs_m = {m_state, m_err, m_fwd_b, m_fwd_a, m_freeze, m_flush, m_bubble, m_stall_ifid, m_stall_pc};
    assign obs_t = {t_state, t_err, t_fwd_b, t_fwd_a, t_freeze, t_flush, t_bubble, t_stall_ifid, t_stall_pc};

    always #5 clk = ~clk;

    hazard_ctrl u_dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(s.id_rs1), .id_rs2(s.id_rs2), .id_use1(s.id_use1), .id_use2(s.id_use2),
        .ex_rs1(s.ex_rs1), .ex_rs2(s.ex_rs2), .ex_rd(s.ex_rd),
        .ex_reg_wb(s.ex_reg_wb), .ex_load(s.ex_load), .ex_redirect(s.ex_redirect),
        .mem_req(s.mem_req), .mem_ready(s.mem_ready),
        .stall_pc(m_stall_pc), .stall_ifid(m_stall_ifid), .bubble_idex(m_bubble),
        .flush_ifid(m_flush), .freeze(m_freeze), .fwd_a(m_fwd_a), .fwd_b(m_fwd_b),
        .mem_err(m_err), .state(m_state)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall(m_perf_stall), .perf_flush(m_perf_flush), .perf_lu(m_perf_lu)
`endif
    );

    hazard_ctrl #(.RA_W(5), .MEM_TO(3)) u_to (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(s.id_rs1), .id_rs2(s.id_rs2), .id_use1(s.id_use1), .id_use2(s.id_use2),
        .ex_rs1(s.ex_rs1), .ex_rs2(s.ex_rs2), .ex_rd(s.ex_rd),
        .ex_reg_wb(s.ex_reg_wb), .ex_load(s.ex_load), .ex_redirect(s.ex_redirect),
        .mem_req(s.mem_req), .mem_ready(s.mem_ready),
        .stall_pc(t_stall_pc), .stall_ifid(t_stall_ifid), .bubble_idex(t_bubble),
        .flush_ifid(t_flush), .freeze(t_freeze), .fwd_a(t_fwd_a), .fwd_b(t_fwd_b),
        .mem_err(t_err), .state(t_state)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall(t_perf_stall), .perf_flush(t_perf_flush), .perf_lu(t_perf_lu)
`endif
    );

    function automatic logic [11:0] ev(input logic [1:0] st, input logic err,
                                       input logic [1:0] fb, input logic [1:0] fa,
                                       input logic [4:0] ctl);
        return {st, err, fb, fa, ctl};
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        s = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        logic [11:0] got;
        reset_n = 1'b0;
        s = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
        exp_q.push_back({1'b1, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = e[12] ? obs_t : obs_m;
            checks++;
            if (got !== e[11:0]) begin
                errors++;
                $display("FAIL reset inst%0d: got %h expected %h", e[12], got, e[11:0]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        logic [12:0] e;
        logic [11:0] got;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            s = '0;
            case (i)
                0: begin
                    s.ex_load = 1'b1; s.ex_reg_wb = 1'b1; s.ex_rd = 5'd5;
                    s.id_rs1 = 5'd5; s.id_use1 = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_LU)});
                end
                1: begin
                    // ID/EX holds the bubble; stale dest must not reach the MEM tracker
                    s.ex_reg_wb = 1'b1; s.ex_rd = 5'd5; s.ex_rs1 = 5'd5;
                    s.id_rs1 = 5'd5; s.id_use1 = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
                end
                2: begin
                    s.ex_rs1 = 5'd5; s.ex_rd = 5'd6; s.ex_reg_wb = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b10, C_NONE)});
                end
                3: begin
                    s.ex_load = 1'b1; s.ex_reg_wb = 1'b1; s.ex_rd = 5'd8;
                    s.id_rs1 = 5'd8; s.id_rs2 = 5'd8;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
                end
                default: begin
                    s.ex_load = 1'b1; s.ex_reg_wb = 1'b1; s.ex_rd = 5'd0;
                    s.id_rs1 = 5'd0; s.id_use1 = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
                end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = e[12] ? obs_t : obs_m;
                checks++;
                if (got !== e[11:0]) begin
                    errors++;
                    $display("FAIL load_use[%0d]: got %h expected %h", i, got, e[11:0]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_forward();
        logic [12:0] e;
        logic [11:0] got;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            s = '0;
            case (i)
                0: begin
                    s.ex_rd = 5'd3; s.ex_reg_wb = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
                end
                1: begin
                    s.ex_rs2 = 5'd3; s.ex_rd = 5'd7; s.ex_reg_wb = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b01, 2'b00, C_NONE)});
                end
                2: begin
                    s.ex_rs2 = 5'd3; s.ex_rs1 = 5'd7; s.ex_rd = 5'd0; s.ex_reg_wb = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b10, 2'b01, C_NONE)});
                end
                3: begin
                    s.ex_rs1 = 5'd0; s.ex_rs2 = 5'd7; s.ex_rd = 5'd7; s.ex_reg_wb = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b10, 2'b00, C_NONE)});
                end
                4: begin
                    s.ex_rs1 = 5'd7; s.ex_rd = 5'd7; s.ex_reg_wb = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b01, C_NONE)});
                end
                5: begin
                    s.ex_rs1 = 5'd7; s.ex_rs2 = 5'd7;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b01, 2'b01, C_NONE)});
                end
                default: begin
                    s.ex_rs1 = 5'd7;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b10, C_NONE)});
                end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = e[12] ? obs_t : obs_m;
                checks++;
                if (got !== e[11:0]) begin
                    errors++;
                    $display("FAIL alu_forward[%0d]: got %h expected %h", i, got, e[11:0]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        logic [12:0] e;
        logic [11:0] got;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            s = '0;
            case (i)
                0: begin
                    s.ex_redirect = 1'b1; s.ex_load = 1'b1; s.ex_reg_wb = 1'b1; s.ex_rd = 5'd4;
                    s.id_rs2 = 5'd4; s.id_use2 = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_RD)});
                end
                1: begin
                    s.ex_rs1 = 5'd4;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
                end
                2: begin
                    s.ex_rs1 = 5'd4;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b10, C_NONE)});
                end
                default: begin
                    s.ex_redirect = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_RD)});
                end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = e[12] ? obs_t : obs_m;
                checks++;
                if (got !== e[11:0]) begin
                    errors++;
                    $display("FAIL redirect[%0d]: got %h expected %h", i, got, e[11:0]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [12:0] e;
        logic [11:0] got;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            s = '0;
            if (i == 0) begin
                s.ex_rd = 5'd9; s.ex_reg_wb = 1'b1;
                exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
            end else if (i <= 5) begin
                // redirect during freeze must be suppressed
                s.mem_req = 1'b1; s.mem_ready = (i == 5);
                s.ex_rs1 = 5'd9; s.ex_rd = 5'd10; s.ex_reg_wb = 1'b1; s.ex_redirect = 1'b1;
                exp_q.push_back({1'b0, ev((i == 1) ? 2'd0 : 2'd1, 1'b0, 2'b00, 2'b01, C_FZ)});
            end else if (i == 6) begin
                s.ex_rs1 = 5'd9; s.ex_rd = 5'd10; s.ex_reg_wb = 1'b1;
                exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b01, C_NONE)});
            end else begin
                s.ex_rs1 = 5'd9; s.ex_rs2 = 5'd10;
                exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b01, 2'b10, C_NONE)});
            end
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = e[12] ? obs_t : obs_m;
                checks++;
                if (got !== e[11:0]) begin
                    errors++;
                    $display("FAIL mem_wait[%0d]: got %h expected %h", i, got, e[11:0]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [12:0] e;
        logic [11:0] got;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            s = '0;
            reset_n = 1'b1;
            case (i)
                0: begin
                    s.mem_req = 1'b1;
                    exp_q.push_back({1'b1, ev(2'd0, 1'b0, 2'b00, 2'b00, C_FZ)});
                end
                1, 2: begin
                    s.mem_req = 1'b1;
                    exp_q.push_back({1'b1, ev(2'd1, 1'b0, 2'b00, 2'b00, C_FZ)});
                end
                3: begin
                    s.mem_req = 1'b1;
                    exp_q.push_back({1'b1, ev(2'd2, 1'b1, 2'b00, 2'b00, C_NONE)});
                end
                4: exp_q.push_back({1'b1, ev(2'd0, 1'b1, 2'b00, 2'b00, C_NONE)});
                5: begin
                    s.mem_req = 1'b1; s.mem_ready = 1'b1;
                    exp_q.push_back({1'b1, ev(2'd0, 1'b1, 2'b00, 2'b00, C_NONE)});
                end
                6: reset_n = 1'b0;
                default: exp_q.push_back({1'b1, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = e[12] ? obs_t : obs_m;
                checks++;
                if (got !== e[11:0]) begin
                    errors++;
                    $display("FAIL timeout[%0d]: got %h expected %h", i, got, e[11:0]);
                end
            end
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
    endtask

    task automatic test_reset_in_wait();
        logic [12:0] e;
        logic [11:0] got;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            s = '0;
            reset_n = 1'b1;
            case (i)
                0: begin
                    s.mem_req = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_FZ)});
                end
                1: begin
                    s.mem_req = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd1, 1'b0, 2'b00, 2'b00, C_FZ)});
                end
                2: begin
                    // reset takes effect at the edge; this cycle is still WAIT
                    reset_n = 1'b0; s.mem_req = 1'b1;
                    exp_q.push_back({1'b0, ev(2'd1, 1'b0, 2'b00, 2'b00, C_FZ)});
                end
                default: begin
                    exp_q.push_back({1'b0, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
                    exp_q.push_back({1'b1, ev(2'd0, 1'b0, 2'b00, 2'b00, C_NONE)});
                end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = e[12] ? obs_t : obs_m;
                checks++;
                if (got !== e[11:0]) begin
                    errors++;
                    $display("FAIL reset_in_wait[%0d] inst%0d: got %h expected %h", i, e[12], got, e[11:0]);
                end
            end
`ifdef HAZ_PERF_CNT_EN
            if (i == 3) begin
                checks++;
                if (m_perf_stall !== 32'd0) begin
                    errors++;
                    $display("FAIL perf_stall_reset: got %0d expected 0", m_perf_stall);
                end
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        s = '0;
        test_reset();
        test_load_use();
        test_alu_forward();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
